// File: rtl/kfpga_config_loader.sv
// kfpga_config_loader: clears the kFPGA config chain, then shifts CHAIN_LENGTH bitstream bits LSB-first into it
module kfpga_config_loader #(
    parameter int WORD_WIDTH   = 32,
    parameter int CHAIN_LENGTH = 1024,
    parameter int CLEAR_CYCLES = 4,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [WORD_WIDTH-1:0]  word_data,
    input  logic                   word_valid,
    output logic                   word_ready,
    output logic                   config_out,
    output logic                   config_enable,
    output logic                   config_nreset,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [COUNT_WIDTH-1:0] bit_count
);
    localparam logic [COUNT_WIDTH-1:0] CL = COUNT_WIDTH'(CHAIN_LENGTH);
    localparam logic [COUNT_WIDTH-1:0] WW = COUNT_WIDTH'(WORD_WIDTH);
    localparam logic [COUNT_WIDTH-1:0] CC = COUNT_WIDTH'(CLEAR_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DONE, ERROR} state_t;

    state_t                  state_q;
    logic [WORD_WIDTH-1:0]   sreg_q;
    logic [COUNT_WIDTH-1:0]  left_q, acc_q, clr_q, bc_q, rem, take;
    logic                    out_q, en_q, nres_q, busy_q, done_q, err_q, hs;

    // left_q counts bits of the current word still to be presented, including the one on config_out,
    // so a new word may be taken while the last bit is on the wire without leaving a bubble
    always_comb begin
        rem        = CL - acc_q;
        take       = (rem > WW) ? WW : rem;
        word_ready = (state_q == SHIFT) && (left_q <= COUNT_WIDTH'(1)) && (acc_q < CL) && !abort;
        hs         = word_valid && word_ready;
    end

    // Control FSM with registered chain outputs; bit_count trails config_enable by one edge
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            left_q  <= '0;
            acc_q   <= '0;
            clr_q   <= '0;
            bc_q    <= '0;
            out_q   <= 1'b0;
            en_q    <= 1'b0;
            nres_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            bc_q <= bc_q + COUNT_WIDTH'(en_q);
            if (abort && (state_q == CLEAR || state_q == SHIFT)) begin
                state_q <= ERROR;
                err_q   <= 1'b1;
                busy_q  <= 1'b0;
                en_q    <= 1'b0;
                out_q   <= 1'b0;
                nres_q  <= 1'b1;
                sreg_q  <= '0;
                left_q  <= '0;
            end else begin
                case (state_q)
                    IDLE, DONE, ERROR: if (start) begin
                        state_q <= CLEAR;
                        bc_q    <= '0;
                        acc_q   <= '0;
                        left_q  <= '0;
                        sreg_q  <= '0;
                        clr_q   <= '0;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        nres_q  <= 1'b0;
                    end
                    CLEAR: if (clr_q == CC) begin
                        state_q <= SHIFT;
                        nres_q  <= 1'b1;
                    end else begin
                        clr_q <= clr_q + 1'b1;
                    end
                    SHIFT: if (en_q && bc_q == CL - 1'b1) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        en_q    <= 1'b0;
                        out_q   <= 1'b0;
                        left_q  <= '0;
                    end else if (hs) begin
                        sreg_q <= word_data >> 1;
                        out_q  <= word_data[0];
                        en_q   <= 1'b1;
                        left_q <= take;
                        acc_q  <= acc_q + take;
                    end else if (left_q > COUNT_WIDTH'(1)) begin
                        sreg_q <= sreg_q >> 1;
                        out_q  <= sreg_q[0];
                        en_q   <= 1'b1;
                        left_q <= left_q - 1'b1;
                    end else begin
                        left_q <= '0;
                        en_q   <= 1'b0;
                        out_q  <= 1'b0;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign config_out    = out_q;
    assign config_enable = en_q;
    assign config_nreset = nres_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = err_q;
    assign bit_count     = bc_q;
endmodule

// File: tb/tb_kfpga_config_loader.sv
// tb_kfpga_config_loader: randomized scenario bench against a word-list bitstream model
module tb_kfpga_config_loader;
    localparam int W  = 32;
    localparam int CL = 72;
    localparam int CC = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset, start, abort, word_valid;
    logic [W-1:0]  word_data;
    logic          word_ready, config_out, config_enable, config_nreset, busy, done, error;
    logic [CW-1:0] bit_count;

    int errs = 0;
    int checks = 0;
    logic [W-1:0] wq[$];
    bit got[$], exp_q[$];
    int hs_cnt, nres_cnt, starve_cnt;
    bit en_in_clear, timed_out;

    kfpga_config_loader #(.WORD_WIDTH(W), .CHAIN_LENGTH(CL), .CLEAR_CYCLES(CC), .COUNT_WIDTH(CW)) dut (
        .clock(clk), .reset(reset), .start(start), .abort(abort),
        .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
        .config_out(config_out), .config_enable(config_enable), .config_nreset(config_nreset),
        .busy(busy), .done(done), .error(error), .bit_count(bit_count)
    );

    always #5 clk = ~clk;

    // Expected chain contents: each word contributes its low bits until the chain is full
    function automatic void build_exp();
        int rem = CL;
        exp_q.delete();
        foreach (wq[i])
            for (int b = 0; b < W && rem > 0; b++) begin
                exp_q.push_back(wq[i][b]);
                rem--;
            end
    endfunction

    // Index of the first differing bit among the first n, or -1 when they all agree
    function automatic int seq_diff(input int n);
        if (got.size() < n || exp_q.size() < n) return -2;
        for (int i = 0; i < n; i++)
            if (got[i] != exp_q[i]) return i;
        return -1;
    endfunction

    // Runs one load: pulses start, feeds wq, records the chain activity; optional gap and event injection
    task automatic drive_load(input int gap_word, input int gap_len, input int rnd_pct, input int inj_kind, input int inj_at);
        int wi = 0;
        int gap_left = gap_len;
        int pend = 0;
        bit injected = 0;
        bit seen = 0;
        bit gap_now;
        got.delete();
        hs_cnt = 0; nres_cnt = 0; starve_cnt = 0; en_in_clear = 0; timed_out = 0;
        for (int cyc = 0; ; cyc++) begin
            @(negedge clk);
            if (cyc > 0) begin
                if (!config_nreset) begin
                    nres_cnt++;
                    if (config_enable) en_in_clear = 1;
                end
                if (config_enable) begin
                    got.push_back(config_out);
                    starve_cnt += pend;
                    pend = 0;
                    seen = 1;
                end else if (seen && busy) pend++;
                if (done || error) break;
            end
            if (cyc > 3000) begin
                timed_out = 1;
                break;
            end
            start = (cyc == 0);
            abort = 0;
            if (inj_kind != 0 && !injected && busy && bit_count == CW'(inj_at)) begin
                injected = 1;
                if (inj_kind == 1) abort = 1;
                else if (inj_kind == 2) start = 1;
                else begin
                    reset = 1;
                    break;
                end
            end
            word_valid = 0;
            word_data = (wi < wq.size()) ? wq[wi] : '0;
            #1;
            gap_now = (wi == gap_word) && (gap_left > 0) && word_ready;
            if (gap_now) gap_left--;
            if (rnd_pct > 0 && $urandom_range(99) < rnd_pct) gap_now = 1;
            word_valid = (wi < wq.size()) && !gap_now;
            #1;
            if (word_valid && word_ready) begin
                hs_cnt++;
                wi++;
            end
        end
        start = 0; abort = 0; word_valid = 0;
    endtask

    task automatic test_reset();
        reset = 1; start = 0; abort = 0; word_valid = 0; word_data = '0;
        repeat (2) @(negedge clk);
        checks++; if (config_out !== 1'b0) begin errs++; $display("FAIL reset_out: got %b want 0", config_out); end
        checks++; if (config_enable !== 1'b0) begin errs++; $display("FAIL reset_en: got %b want 0", config_enable); end
        checks++; if (config_nreset !== 1'b1) begin errs++; $display("FAIL reset_nres: got %b want 1", config_nreset); end
        checks++; if ({busy, done, error} !== 3'b000) begin errs++; $display("FAIL reset_flags: got %b want 000", {busy, done, error}); end
        checks++; if (bit_count !== '0) begin errs++; $display("FAIL reset_count: got %0d want 0", bit_count); end
        checks++; if (word_ready !== 1'b0) begin errs++; $display("FAIL reset_ready: got %b want 0", word_ready); end
        reset = 0;
        @(negedge clk);
    endtask

    task automatic test_full_load();
        logic [7:0] v;
        int d;
        wq = '{32'hA5A5A5A5, 32'h0000FFFF, 32'hFFFFFF3C};
        build_exp();
        drive_load(-1, 0, 0, 0, 0);
        d = seq_diff(CL);
        checks++; if (timed_out) begin errs++; $display("FAIL full_timeout: got timeout want done"); end
        checks++; if (got.size() != CL) begin errs++; $display("FAIL full_bits: got %0d want %0d", got.size(), CL); end
        checks++; if (d != -1) begin errs++; $display("FAIL full_order: got first diff at %0d want -1", d); end
        checks++; if (nres_cnt != CC) begin errs++; $display("FAIL full_clear: got %0d want %0d", nres_cnt, CC); end
        checks++; if (en_in_clear) begin errs++; $display("FAIL full_en_in_clear: got 1 want 0"); end
        checks++; if (starve_cnt != 0) begin errs++; $display("FAIL full_bubbles: got %0d want 0", starve_cnt); end
        checks++; if (hs_cnt != 3) begin errs++; $display("FAIL full_handshakes: got %0d want 3", hs_cnt); end
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errs++; $display("FAIL full_done: got done=%b busy=%b want 1 0", done, busy); end
        checks++; if (bit_count !== CW'(CL)) begin errs++; $display("FAIL full_count: got %0d want %0d", bit_count, CL); end
        v = '0;
        if (got.size() >= CL) for (int i = 0; i < 8; i++) v[i] = got[CL - 8 + i];
        checks++; if (v !== 8'h3C) begin errs++; $display("FAIL full_last8: got %h want 3c", v); end
        v = '0;
        if (got.size() >= 8) for (int i = 0; i < 8; i++) v[i] = got[i];
        checks++; if (v !== 8'hA5) begin errs++; $display("FAIL full_first8: got %h want a5", v); end
    endtask

    task automatic test_oversupply();
        wq = '{$urandom, $urandom, $urandom, $urandom};
        build_exp();
        drive_load(-1, 0, 0, 0, 0);
        checks++; if (hs_cnt != 3) begin errs++; $display("FAIL over_handshakes: got %0d want 3", hs_cnt); end
        checks++; if (seq_diff(CL) != -1) begin errs++; $display("FAIL over_order: got diff %0d want -1", seq_diff(CL)); end
        word_data = wq[3];
        word_valid = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (word_ready !== 1'b0 || done !== 1'b1) begin errs++; $display("FAIL over_idle: got ready=%b done=%b want 0 1", word_ready, done); end
        end
        word_valid = 0;
    endtask

    task automatic test_starvation();
        wq = '{$urandom, $urandom, $urandom};
        build_exp();
        drive_load(1, 5, 0, 0, 0);
        checks++; if (timed_out) begin errs++; $display("FAIL starve_timeout: got timeout want done"); end
        checks++; if (starve_cnt != 5) begin errs++; $display("FAIL starve_gaps: got %0d want 5", starve_cnt); end
        checks++; if (seq_diff(CL) != -1 || got.size() != CL) begin errs++; $display("FAIL starve_order: got diff %0d size %0d want -1 %0d", seq_diff(CL), got.size(), CL); end
        checks++; if (bit_count !== CW'(CL) || done !== 1'b1) begin errs++; $display("FAIL starve_end: got count=%0d done=%b want %0d 1", bit_count, done, CL); end
    endtask

    task automatic test_start_ignored();
        wq = '{$urandom, $urandom, $urandom};
        build_exp();
        drive_load(-1, 0, 0, 2, 10);
        checks++; if (nres_cnt != CC) begin errs++; $display("FAIL ign_clear: got %0d want %0d", nres_cnt, CC); end
        checks++; if (seq_diff(CL) != -1 || got.size() != CL) begin errs++; $display("FAIL ign_order: got diff %0d size %0d want -1 %0d", seq_diff(CL), got.size(), CL); end
        checks++; if (bit_count !== CW'(CL) || done !== 1'b1) begin errs++; $display("FAIL ign_end: got count=%0d done=%b want %0d 1", bit_count, done, CL); end
    endtask

    task automatic test_abort();
        wq = '{$urandom, $urandom, $urandom};
        build_exp();
        drive_load(-1, 0, 0, 1, 40);
        checks++; if (error !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin errs++; $display("FAIL abort_flags: got err=%b busy=%b done=%b want 1 0 0", error, busy, done); end
        checks++; if (config_enable !== 1'b0 || config_nreset !== 1'b1) begin errs++; $display("FAIL abort_chain: got en=%b nres=%b want 0 1", config_enable, config_nreset); end
        checks++; if (got.size() != 41 || seq_diff(41) != -1) begin errs++; $display("FAIL abort_bits: got size %0d diff %0d want 41 -1", got.size(), seq_diff(41)); end
        start = 1;
        @(negedge clk);
        start = 0;
        checks++; if (error !== 1'b0 || busy !== 1'b1 || config_nreset !== 1'b0) begin errs++; $display("FAIL abort_restart: got err=%b busy=%b nres=%b want 0 1 0", error, busy, config_nreset); end
        checks++; if (bit_count !== '0) begin errs++; $display("FAIL abort_restart_count: got %0d want 0", bit_count); end
        abort = 1;
        @(negedge clk);
        abort = 0;
        checks++; if (error !== 1'b1 || config_nreset !== 1'b1 || busy !== 1'b0) begin errs++; $display("FAIL abort_in_clear: got err=%b nres=%b busy=%b want 1 1 0", error, config_nreset, busy); end
    endtask

    task automatic test_reset_midload();
        wq = '{$urandom, $urandom, $urandom};
        build_exp();
        drive_load(-1, 0, 0, 3, 50);
        @(negedge clk);
        checks++; if ({config_out, config_enable, config_nreset} !== 3'b001) begin errs++; $display("FAIL midreset_chain: got %b want 001", {config_out, config_enable, config_nreset}); end
        checks++; if ({busy, done, error, word_ready} !== 4'b0000) begin errs++; $display("FAIL midreset_flags: got %b want 0000", {busy, done, error, word_ready}); end
        checks++; if (bit_count !== '0) begin errs++; $display("FAIL midreset_count: got %0d want 0", bit_count); end
        reset = 0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || word_ready !== 1'b0) begin errs++; $display("FAIL midreset_idle: got busy=%b ready=%b want 0 0", busy, word_ready); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            wq = '{$urandom, $urandom, $urandom};
            build_exp();
            drive_load(-1, 0, 30, 0, 0);
            checks++; if (timed_out || seq_diff(CL) != -1 || got.size() != CL) begin errs++; $display("FAIL rnd_order%0d: got diff %0d size %0d want -1 %0d", r, seq_diff(CL), got.size(), CL); end
            checks++; if (hs_cnt != 3 || nres_cnt != CC) begin errs++; $display("FAIL rnd_hs%0d: got hs=%0d clr=%0d want 3 %0d", r, hs_cnt, nres_cnt, CC); end
            checks++; if (bit_count !== CW'(CL) || done !== 1'b1) begin errs++; $display("FAIL rnd_end%0d: got count=%0d done=%b want %0d 1", r, bit_count, done, CL); end
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_oversupply();
        test_starvation();
        test_start_ignored();
        test_abort();
        test_reset_midload();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
